iter_muldiv_unit: RTL

//  Iterative unsigned multiply/divide execution stage for the lab6 datapath.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 50 +++++
 rtl/iter_muldiv_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide stage: operation codes,
// FSM states, default width and small op-decoding helpers.
package muldiv_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV_Q  = 2'b10,
    OP_DIV_R  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WB   = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    logic res;
    case (op)
      OP_DIV_Q, OP_DIV_R:   res = 1'b1;
      OP_MUL_LO, OP_MUL_HI: res = 1'b0;
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  // Upper result half: product high word or the remainder, both held in acc.
  function automatic logic op_takes_acc(input op_e op);
    logic res;
    case (op)
      OP_MUL_HI, OP_DIV_R: res = 1'b1;
      OP_MUL_LO, OP_DIV_Q: res = 1'b0;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first
// restoring divide over an {acc, shreg} register pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] shreg_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  input  logic                  div_mode_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] shreg_o
);

  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH:0]   partial;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH-1:0] rem_sub;
  logic                  q_bit;

  // Single multiply or divide iteration selected by div_mode_i.
  always_comb begin
    add_sum   = {1'b0, acc_i} + {1'b0, operand_i};
    rem_shift = {acc_i, shreg_i[DATA_WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, operand_i});
    // The true difference is below the divisor, so its low bits suffice.
    rem_sub   = rem_shift[DATA_WIDTH-1:0] - operand_i;
    partial   = {1'b0, acc_i};
    acc_o     = acc_i;
    shreg_o   = shreg_i;
    if (div_mode_i) begin
      if (q_bit) begin
        acc_o = rem_sub;
      end else begin
        acc_o = rem_shift[DATA_WIDTH-1:0];
      end
      shreg_o = {shreg_i[DATA_WIDTH-2:0], q_bit};
    end else begin
      if (shreg_i[0]) begin
        partial = add_sum;
      end else begin
        partial = {1'b0, acc_i};
      end
      acc_o   = partial[DATA_WIDTH:1];
      shreg_o = {partial[0], shreg_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative unsigned multiply/divide execution stage: latches an issue, runs
// DATA_WIDTH steps, then drives the register-file write port for one cycle.
module iter_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  RegWrite
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  reg_write_q, reg_write_d;

  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [DATA_WIDTH-1:0] shreg_nxt;

  muldiv_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .acc_i     (acc_q),
    .shreg_i   (shreg_q),
    .operand_i (operand_q),
    .div_mode_i(op_is_div(op_q)),
    .acc_o     (acc_nxt),
    .shreg_o   (shreg_nxt)
  );

  // FSM next-state, datapath update and write-back output generation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dest_d      = dest_q;
    operand_d   = operand_q;
    acc_d       = acc_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    reg_write_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          op_d      = op_e'(op);
          dest_d    = dest_addr;
          // Multiply is commutative, so operand_a always enters the shift register.
          shreg_d   = operand_a;
          operand_d = operand_b;
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RUN: begin
        acc_d   = acc_nxt;
        shreg_d = shreg_nxt;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d     = S_WB;
          done_d      = 1'b1;
          waddr_d     = dest_q;
          reg_write_d = (dest_q != '0);
          if (op_takes_acc(op_q)) begin
            wdata_d = acc_nxt;
          end else begin
            wdata_d = shreg_nxt;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL_LO;
      dest_q      <= '0;
      operand_q   <= '0;
      acc_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign write_data    = wdata_q;
  assign write_address = waddr_q;
  assign RegWrite      = reg_write_q;

endmodule
